muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit. It replaces the fixed 32-bit multiplier feeding the HI/LO registers and adds signed/unsigned modes and division. It sits beside the ALU in the multicycle datapath and is driven by the control unit through a start/done handshake. Operands come from A/B and results go to HI/LO write muxes.

Parameters:
WIDTH, 32, operand width in bits. Must be ≥ 4. hi/lo are each WIDTH bits.
CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets)
start  input  1  request; sampled only in IDLE
op  input  2  00=MULT signed, 01=MULTU, 10=DIV signed, 11=DIVU; captured with start
a  input  WIDTH  multiplicand / dividend; captured with start
b  input  WIDTH  multiplier / divisor; captured with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid
div_zero  output  1  divisor was zero on last DIV/DIVU; held until next accepted start
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset values (reset==0 at an edge, any state): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts with no result.
- States and transitions:
  - IDLE: start=1 → capture op/a/b, clear div_zero. If DIV/DIVU and b==0, go to DONE and set div_zero=1 (hi/lo unchanged). Otherwise go to CALC with counter=WIDTH-1.
  - CALC: one iteration per cycle. Go to FIX when counter==0, else decrement.
  - FIX: apply sign correction, write hi/lo, go to DONE.
  - DONE: done=1 for this cycle only, go to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle following edge E0+WIDTH+1. Div-by-zero: done high in the cycle following E0+1.
- Throughput: a new start is accepted in the IDLE cycle right after DONE. Back-to-back ops therefore issue every WIDTH+3 cycles.
- start while busy=1 is ignored and has no side effects. a/b/op changes after capture are ignored.
- Signed modes: operate on magnitudes (|x| as unsigned WIDTH bits, so |MIN_INT| = 2^(WIDTH-1)).
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
- Multiply: shift-add over WIDTH iterations into a 2*WIDTH accumulator. {hi,lo} = full 2*WIDTH product. No overflow flag.
- Divide: restoring, one quotient bit per iteration MSB-first. lo=quotient, hi=remainder.
  - |remainder| < |b|.
  - Signed MIN_INT / -1 yields lo=MIN_INT, hi=0 (no trap).
- hi/lo change only on the FIX edge (or reset). They hold their value otherwise, including during a following operation.
- div_zero is a registered output, updated only on start acceptance and reset.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 → done at E0+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high E0+1..E0+33.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU b=0 after a prior result hi=2/lo=14 → done one cycle after start edge, div_zero=1, hi/lo stay 2/14. Next accepted MULT clears div_zero.
- start pulsed again mid-CALC with different operands → ignored, first result unchanged. reset=0 at E0+10 → busy=0, done never pulses, hi=lo=0.
- WIDTH=8, MULT a=0x80, b=0x80 → hi=0x40, lo=0x00, done in the cycle after E0+9. DIV a=0x81 (-127), b=0x0A → lo=0xF4 (-12), hi=0xF9 (-7).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, reset (sync, active-low), start/op/a/b request; busy,
//   done (1-cycle pulse), div_zero, hi/lo results (product or rem/quot).
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   md;
    logic [2*WIDTH-1:0] acc;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    assign b_zero    = op[1] && (b == '0);

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    // The add is WIDTH+1 bits so the carry shifts into the top on the
    // right shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, md} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}.
    // Quotient bits enter at the bottom as dividend bits leave the top.
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, md};
    // The true difference is below md, so it fits in WIDTH bits.
    assign div_sub   = div_trial[WIDTH-1:0] - md;
    assign div_rem   = div_ge ? div_sub : div_trial[WIDTH-1:0];
    assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] p_fix;

    assign q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign p_fix = neg_q ? -acc : acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == '0) begin
                    state_n = S_FIX;
                end
            end
            S_FIX:  state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            md       <= '0;
            acc      <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        div_zero <= b_zero;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        cnt      <= CNT_W'(WIDTH - 1);
                        md       <= op[1] ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}},
                                     (op[1] ? mag_a : mag_b)};
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= p_fix;
                    end
                end
                S_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 8-bit instances against an
// arithmetic reference model, directed and random operations.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic        dz8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(dz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    int ncmp = 0;
    int nfail = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;
    logic [7:0]  e8_hi = '0;
    logic [7:0]  e8_lo = '0;
    logic        e8_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        ncmp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Returns {hi,lo} in the low 2*w bits, computed with plain
    // 64-bit integer arithmetic on the interpreted operand values.
    function automatic logic [63:0] ref_op(input int w,
            input logic [1:0] o, input logic [31:0] x,
            input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] mw, p;
        mw = (64'd1 << w) - 64'd1;
        sx = longint'({32'd0, x});
        sy = longint'({32'd0, y});
        if (!o[0]) begin
            if (x[w-1]) sx = sx - (longint'(1) << w);
            if (y[w-1]) sy = sy - (longint'(1) << w);
        end
        if (!o[1]) begin
            p = sx * sy;
            if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
            return p;
        end
        q = sx / sy;
        r = sx % sy;
        return ((r & mw) << w) | (q & mw);
    endfunction

    task automatic run32(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit poke);
        int n;
        int want_lat;
        logic [63:0] r;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check("busy32_after_start", 64'(busy), 64'd1);
                a = $urandom;
                b = $urandom;
                op = 2'($urandom);
            end
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
        end while (!done && n < 100);
        if (o[1] && y == 32'd0) begin
            want_lat = 1;
            exp_dz = 1'b1;
        end else begin
            r = ref_op(32, o, x, y);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            exp_dz = 1'b0;
            want_lat = 34;
        end
        check("latency32", 64'(n), 64'(want_lat));
        check("hi32", 64'(hi), 64'(exp_hi));
        check("lo32", 64'(lo), 64'(exp_lo));
        check("div_zero32", 64'(dz), 64'(exp_dz));
        @(negedge clk);
        check("done32_one_cycle", 64'(done), 64'd0);
        check("busy32_idle", 64'(busy), 64'd0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y);
        int n;
        int want_lat;
        logic [63:0] r;
        op8 = o;
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end while (!done8 && n < 100);
        if (o[1] && y == 8'd0) begin
            want_lat = 1;
            e8_dz = 1'b1;
        end else begin
            r = ref_op(8, o, {24'd0, x}, {24'd0, y});
            e8_hi = r[15:8];
            e8_lo = r[7:0];
            e8_dz = 1'b0;
            want_lat = 10;
        end
        check("latency8", 64'(n), 64'(want_lat));
        check("hi8", 64'(hi8), 64'(e8_hi));
        check("lo8", 64'(lo8), 64'(e8_lo));
        check("div_zero8", 64'(dz8), 64'(e8_dz));
        @(negedge clk);
        check("done8_one_cycle", 64'(done8), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        start8 = 1'b0;
        op8 = '0;
        a8 = '0;
        b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run32(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run32(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run32(2'b11, 32'd100, 32'd7, 1'b0);
        run32(2'b11, 32'd55, 32'd0, 1'b0);
        run32(2'b00, 32'd12345, 32'hFFFF_0000, 1'b0);
        run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run32(2'b10, 32'h1234_5678, 32'd0, 1'b0);
        run32(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        run32(2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin
                    rx = 32'h8000_0000;
                    ry = 32'hFFFF_FFFF;
                end
                2: ry = 32'($urandom_range(1, 20));
                3: ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run32(ro, rx, ry, 1'b0);
        end

        run8(2'b00, 8'h80, 8'h80);
        run8(2'b10, 8'h81, 8'h0A);
        run8(2'b11, 8'hFF, 8'h00);
        run8(2'b10, 8'h80, 8'hFF);
        run8(2'b01, 8'hFF, 8'hFF);
        for (int i = 0; i < 12; i++) begin
            run8(2'($urandom), 8'($urandom), 8'($urandom));
        end

        op = 2'b00;
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        n = 0;
        while (n < 11) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 10) reset = 1'b0;
        end
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'(exp_hi));
        check("abort_lo", 64'(lo), 64'(exp_lo));
        check("abort_dz", 64'(dz), 64'(exp_dz));
        check("abort_hi8", 64'(hi8), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        run32(2'b11, 32'd1000, 32'd33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
